seq_bit_serializer: RTL

- Parallel-to-serial stage that sits directly upstream of the overlapping sequence detector.
- Accepts W-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB first.
- Its ser_data output drives the detector's serial data input.
- Supports gapless back-to-back words, so detector patterns that span word boundaries are preserved.

---
 rtl/seq_bit_serializer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: W-bit words in over valid/ready, shifted out MSB first, gapless back-to-back.
// Optional even-parity trailer bit per word is enabled by defining SEQ_SER_PARITY_EN.
module seq_bit_serializer #(
    parameter int unsigned W          = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_data,
    output logic         ser_valid,
    output logic         busy,
    output logic         word_done
);

    localparam int unsigned    CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef SEQ_SER_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ser_data_q, ser_data_d;
    logic           ser_valid_q, ser_valid_d;
    logic           word_done_q, word_done_d;
    logic           ready_s;
    logic           accept_s;

    // Ready decode: the only combinational output, held low throughout reset.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   ready_s = 1'b1;
`ifdef SEQ_SER_PARITY_EN
                ST_SHIFT:  ready_s = 1'b0;
                ST_PARITY: ready_s = 1'b1;
`else
                ST_SHIFT:  ready_s = (cnt_q == LAST);
`endif
                default:   ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = in_valid && ready_s;

    // Next-state and next-output computation; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SEQ_SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    shreg_d = in_data;
                    cnt_d   = '0;
`ifdef SEQ_SER_PARITY_EN
                    par_d   = ^in_data;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != LAST) begin
                    shreg_d = {shreg_q[W-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
`ifdef SEQ_SER_PARITY_EN
                    state_d = ST_PARITY;
`else
                    // Reloading on the last bit is what makes consecutive words gapless.
                    if (accept_s) begin
                        state_d = ST_SHIFT;
                        shreg_d = in_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef SEQ_SER_PARITY_EN
            ST_PARITY: begin
                cnt_d = '0;
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    shreg_d = in_data;
                    par_d   = ^in_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        ser_valid_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SHIFT:  ser_data_d = shreg_d[W-1];
`ifdef SEQ_SER_PARITY_EN
            ST_PARITY: ser_data_d = par_d;
`endif
            default:   ser_data_d = IDLE_LEVEL;
        endcase
`ifdef SEQ_SER_PARITY_EN
        word_done_d = (state_d == ST_PARITY);
`else
        word_done_d = (state_d == ST_SHIFT) && (cnt_d == LAST);
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_data_q  <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
`ifdef SEQ_SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready  = ready_s;
    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign busy      = ser_valid_q;
    assign word_done = word_done_q;

endmodule
